// File: rtl/stream_mux_rr_pkg.sv
// mux_pkg: shared limits and the round-robin pick helper for stream_mux_rr.
package mux_pkg;
   localparam int MAX_INPUTS = 16;
   localparam int IDX_W = $clog2(MAX_INPUTS);
   typedef struct packed {
      logic             found;
      logic [IDX_W-1:0] idx;
   } pick_t;
   // First valid channel after ptr, wrapping within the n live channels.
   function automatic pick_t rr_pick(input logic [MAX_INPUTS-1:0] valid, input logic [IDX_W-1:0] ptr, input int n);
      pick_t p;
      int k;
      p = '0;
      for (int i = 1; i <= MAX_INPUTS; i++) begin
         k = (int'(ptr) + i) % n;
         if (i <= n && !p.found && valid[k]) begin
            p.found = 1'b1;
            p.idx = IDX_W'(k);
         end
      end
      return p;
   endfunction
endpackage

// File: rtl/stream_mux_rr_if.sv
// stream_mux_rr_if: N input valid/ready streams plus one registered output stream.
interface stream_mux_rr_if #(parameter int N_INPUTS = 4, parameter int BUS_WIDTH = 4);
   localparam int SEL_W = $clog2(N_INPUTS);
   logic [N_INPUTS-1:0]           in_valid;
   logic [N_INPUTS*BUS_WIDTH-1:0] in_data;
   logic [N_INPUTS-1:0]           in_last;
   logic [N_INPUTS-1:0]           in_ready;
   logic                          out_valid;
   logic [BUS_WIDTH-1:0]          out_data;
   logic                          out_last;
   logic [SEL_W-1:0]              out_sel;
   logic                          out_ready;
   modport master (output in_valid, in_data, in_last, out_ready, input in_ready, out_valid, out_data, out_last, out_sel);
   modport slave (input in_valid, in_data, in_last, out_ready, output in_ready, out_valid, out_data, out_last, out_sel);
endinterface

// File: rtl/stream_mux_rr_arbiter.sv
// rr_arbiter: combinational round-robin grant with a pointer that moves to the accepted channel.
module rr_arbiter import mux_pkg::*; #(
   parameter int N_INPUTS = 4,
   localparam int SEL_W = $clog2(N_INPUTS)
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [N_INPUTS-1:0] valid,
   input  logic                accept,
   input  logic [SEL_W-1:0]    accept_idx,
   output logic [SEL_W-1:0]    grant,
   output logic                found
);
   logic [SEL_W-1:0] rr_ptr;
   pick_t pick;
   assign pick = rr_pick(MAX_INPUTS'(valid), IDX_W'(rr_ptr), N_INPUTS);
   assign grant = SEL_W'(pick.idx);
   assign found = pick.found;
   always_ff @(posedge clk)
      if (reset) rr_ptr <= SEL_W'(N_INPUTS - 1);
      else if (accept) rr_ptr <= accept_idx;
endmodule

// File: rtl/stream_mux_rr.sv
// stream_mux_rr: N-to-1 round-robin stream mux with a one-entry output register.
// Define STREAM_MUX_PKT_LOCK_EN to hold the grant on one channel until its last beat.
module stream_mux_rr import mux_pkg::*; #(
   parameter int N_INPUTS = 4,
   parameter int BUS_WIDTH = 4
) (
   input logic clk,
   input logic reset,
   stream_mux_rr_if.slave bus
);
   localparam int SEL_W = $clog2(N_INPUTS);
   logic load_en, found, xfer;
   logic [SEL_W-1:0] pick_idx, g;
`ifdef STREAM_MUX_PKT_LOCK_EN
   logic lock;
   logic [SEL_W-1:0] lock_idx;
   assign g = lock ? lock_idx : pick_idx;
   always_ff @(posedge clk)
      if (reset) begin
         lock <= 1'b0;
         lock_idx <= '0;
      end else if (xfer) begin
         lock <= !bus.in_last[g];
         lock_idx <= g;
      end
`else
   assign g = pick_idx;
`endif
   assign load_en = !bus.out_valid || bus.out_ready;
   assign bus.in_ready = N_INPUTS'(load_en && found) << g;
   assign xfer = load_en && bus.in_valid[g];
   rr_arbiter #(.N_INPUTS(N_INPUTS)) u_arb (
      .clk(clk),
      .reset(reset),
      .valid(bus.in_valid),
      .accept(xfer),
      .accept_idx(g),
      .grant(pick_idx),
      .found(found)
   );
   always_ff @(posedge clk)
      if (reset) begin
         bus.out_valid <= 1'b0;
         bus.out_data <= '0;
         bus.out_last <= 1'b0;
         bus.out_sel <= '0;
      end else if (xfer) begin
         bus.out_valid <= 1'b1;
         bus.out_data <= bus.in_data[int'(g)*BUS_WIDTH +: BUS_WIDTH];
         bus.out_last <= bus.in_last[g];
         bus.out_sel <= g;
      end else if (bus.out_ready) bus.out_valid <= 1'b0;
endmodule
